// File: rtl/program_counter_ras.sv
// Program counter with a circular return-address stack.
// Next-PC priority per rising edge: flush, stall, ret, branch_taken, sequential.
// The RAS overwrites its oldest entry when a push arrives while full.
module program_counter_ras #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCWrite,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] PC_Out,
  output logic [XLEN-1:0] PC_Plus,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow,
  output logic            misaligned
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  // ptr_q is the next free slot; the top of stack sits one below it.
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            unf_d;
  logic            push, replace;
  logic [PW-1:0]   top_idx;
  logic [XLEN-1:0] top_val;
  logic [XLEN-1:0] bt_aligned;

  assign PC_Out     = pc_q;
  assign PC_Plus    = pc_q + XLEN'(INC);
  assign misaligned = pc_q[1];
  assign ras_empty  = (cnt_q == '0);
  assign ras_full   = (cnt_q == DEPTH_C);
  assign top_idx    = ptr_q - PW'(1);
  assign top_val    = ras_mem[top_idx];
  assign bt_aligned = {branch_target[XLEN-1:1], 1'b0};

  // Next-PC selection and RAS pointer/count bookkeeping.
  always_comb begin
    pc_d    = PC_Plus;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unf_d   = 1'b0;
    push    = 1'b0;
    replace = 1'b0;
    if (flush) begin
      pc_d = {flush_target[XLEN-1:1], 1'b0};
    end else if (!PCWrite) begin
      pc_d = pc_q;
    end else if (ret) begin
      if (ras_empty) begin
        // Underflow falls back to the supplied target; a coincident call still pushes.
        pc_d  = bt_aligned;
        unf_d = 1'b1;
        push  = call && branch_taken;
      end else begin
        pc_d = top_val;
        if (call && branch_taken) begin
          replace = 1'b1;
        end else begin
          ptr_d = ptr_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end
    end else if (branch_taken) begin
      pc_d = bt_aligned;
      push = call;
    end
    if (push) begin
      ptr_d = ptr_q + PW'(1);
      cnt_d = ras_full ? cnt_q : cnt_q + CW'(1);
    end
  end

  // PC, pointer, count and underflow pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_VECTOR;
      ptr_q         <= '0;
      cnt_q         <= '0;
      ras_underflow <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      ras_underflow <= unf_d;
    end
  end

  // RAS storage; contents are qualified by the count so they carry no reset.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      ras_mem[ptr_q] <= PC_Plus;
    end else if (reset && replace) begin
      ras_mem[top_idx] <= PC_Plus;
    end
  end

endmodule

// File: tb/tb_program_counter_ras.sv
// Scoreboard bench: stimulus queues expected state after each edge, a negedge
// monitor pops and compares. A 32-bit instance shares the stimulus and must
// track the low 32 bits of the 64-bit expectation.
module tb_program_counter_ras;

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic        emp;
    logic        ful;
    logic        unf;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        PCWrite, flush, branch_taken, call, ret;
  logic [63:0] flush_target, branch_target;

  logic [63:0] pc64, plus64;
  logic        emp64, ful64, unf64, mis64;
  logic [31:0] pc32, plus32;
  logic        emp32, ful32, unf32, mis32;

  exp_t exp_q[$];
  exp_t it;
  int   n_checks = 0;
  int   n_fail   = 0;

  program_counter_ras #(.XLEN(64), .RESET_VECTOR(64'h0), .INC(4), .RAS_DEPTH(4)) dut64 (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .flush(flush),
    .flush_target(flush_target), .branch_taken(branch_taken),
    .branch_target(branch_target), .call(call), .ret(ret),
    .PC_Out(pc64), .PC_Plus(plus64), .ras_empty(emp64), .ras_full(ful64),
    .ras_underflow(unf64), .misaligned(mis64)
  );

  program_counter_ras #(.XLEN(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4)) dut32 (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .flush(flush),
    .flush_target(flush_target[31:0]), .branch_taken(branch_taken),
    .branch_target(branch_target[31:0]), .call(call), .ret(ret),
    .PC_Out(pc32), .PC_Plus(plus32), .ras_empty(emp32), .ras_full(ful32),
    .ras_underflow(unf32), .misaligned(mis32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic ok;
      logic [63:0] ep;
      it = exp_q.pop_front();
      ep = it.pc;
      n_checks++;
      ok = (pc64 === ep) && (plus64 === ep + 64'd4) && (mis64 === ep[1]) &&
           (emp64 === it.emp) && (ful64 === it.ful) && (unf64 === it.unf) &&
           (pc32 === ep[31:0]) && (plus32 === ep[31:0] + 32'd4) && (mis32 === ep[1]) &&
           (emp32 === it.emp) && (ful32 === it.ful) && (unf32 === it.unf);
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: got pc64=%h plus64=%h mis=%b e/f/u=%b%b%b pc32=%h plus32=%h e/f/u=%b%b%b, want pc=%h e/f/u=%b%b%b",
                 it.name, pc64, plus64, mis64, emp64, ful64, unf64, pc32, plus32,
                 emp32, ful32, unf32, ep, it.emp, it.ful, it.unf);
      end
    end
  end

  task automatic idle();
    PCWrite       = 1'b1;
    flush         = 1'b0;
    branch_taken  = 1'b0;
    call          = 1'b0;
    ret           = 1'b0;
    flush_target  = '0;
    branch_target = '0;
  endtask

  task automatic expect_state(input string nm, input logic [63:0] pc,
                              input logic e, input logic f, input logic u);
    exp_t x;
    x.name = nm; x.pc = pc; x.emp = e; x.ful = f; x.unf = u;
    exp_q.push_back(x);
  endtask

  // One rising edge with the currently driven inputs, then return to idle.
  task automatic tick(input string nm, input logic [63:0] pc,
                      input logic e, input logic f, input logic u);
    @(posedge clk);
    #1;
    idle();
    expect_state(nm, pc, e, f, u);
  endtask

  task automatic do_call(input logic [63:0] tgt);
    call = 1'b1; branch_taken = 1'b1; branch_target = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rets [4];
    rets[0] = 64'h4004; rets[1] = 64'h3004; rets[2] = 64'h2004; rets[3] = 64'h1004;

    idle();
    reset = 1'b0;
    @(posedge clk); #1;
    expect_state("reset_hold", 64'h0, 1, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    expect_state("reset_release", 64'h0, 1, 0, 0);
    tick("idle1", 64'h4, 1, 0, 0);
    tick("idle2", 64'h8, 1, 0, 0);
    tick("idle3", 64'hC, 1, 0, 0);

    PCWrite = 1'b0; ret = 1'b1;
    tick("stall1", 64'hC, 1, 0, 0);
    PCWrite = 1'b0;
    tick("stall2", 64'hC, 1, 0, 0);

    flush = 1'b1; flush_target = 64'h100;
    tick("flush_100", 64'h100, 1, 0, 0);
    do_call(64'h400);
    tick("call_400", 64'h400, 0, 0, 0);
    ret = 1'b1;
    tick("ret_104", 64'h104, 1, 0, 0);

    for (int i = 0; i < 5; i++) begin
      do_call(64'h1000 * (i + 1));
      tick($sformatf("call5_%0d", i), 64'h1000 * (i + 1), 0, (i >= 3), 0);
    end
    for (int i = 0; i < 4; i++) begin
      ret = 1'b1;
      tick($sformatf("ret4_%0d", i), rets[i], (i == 3), 0, 0);
    end
    ret = 1'b1; branch_target = 64'h777;
    tick("ret_underflow", 64'h776, 1, 0, 1);
    tick("underflow_clear", 64'h77A, 1, 0, 0);

    do_call(64'h900);
    tick("call_900", 64'h900, 0, 0, 0);
    do_call(64'hA00); ret = 1'b1;
    tick("ret_call_replace", 64'h77E, 0, 0, 0);
    ret = 1'b1;
    tick("ret_replaced", 64'h904, 1, 0, 0);
    do_call(64'hB01); ret = 1'b1;
    tick("ret_call_empty", 64'hB00, 0, 0, 1);
    ret = 1'b1;
    tick("ret_after_empty_push", 64'h908, 1, 0, 0);

    do_call(64'h2000);
    tick("call_2000", 64'h2000, 0, 0, 0);
    flush = 1'b1; flush_target = 64'h8000_0001; PCWrite = 1'b0; ret = 1'b1;
    tick("flush_over_stall_ret", 64'h8000_0000, 0, 0, 0);
    ret = 1'b1;
    tick("ret_after_flush", 64'h90C, 1, 0, 0);

    call = 1'b1;
    tick("call_no_branch", 64'h910, 1, 0, 0);
    branch_taken = 1'b1; branch_target = 64'h3003;
    tick("branch_only", 64'h3002, 1, 0, 0);
    ret = 1'b1; branch_target = 64'h3101;
    tick("ret_no_push", 64'h3100, 1, 0, 1);

    flush = 1'b1; flush_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick("flush_top", 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0);
    tick("wrap_zero", 64'h0, 1, 0, 0);

    do_call(64'h5000);
    tick("call_5000", 64'h5000, 0, 0, 0);
    @(negedge clk); #1;
    do_call(64'h6000);
    reset = 1'b0;
    expect_state("async_reset", 64'h0, 1, 0, 0);
    @(negedge clk); #1;
    idle();
    reset = 1'b1;
    tick("post_reset", 64'h4, 1, 0, 0);
    ret = 1'b1; branch_target = 64'h10;
    tick("post_reset_ret", 64'h10, 1, 0, 1);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_counter_ras.md
PROGRAM_COUNTER_RAS -- requirements
Module: program_counter_ras

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, meaning PC width in bits.
REQ-002 The module SHALL have parameter RESET_VECTOR, default 0, meaning the PC value loaded on reset.
REQ-003 The module SHALL have parameter INC, default 4, meaning the sequential PC increment.
REQ-004 The module SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, >=2).
REQ-005 The module SHALL have port clk, input, 1, meaning the single clock (rising edge).
REQ-006 The module SHALL have port reset, input, 1, meaning asynchronous active-low reset (0 = in reset).
REQ-007 The module SHALL have port PCWrite, input, 1, meaning PC update enable (0 = hazard stall).
REQ-008 The module SHALL have port flush, input, 1, meaning a trap or mispredict redirect request.
REQ-009 The module SHALL have port flush_target, input, XLEN, meaning the redirect address.
REQ-010 The module SHALL have port branch_taken, input, 1, meaning a taken branch or jump.
REQ-011 The module SHALL have port branch_target, input, XLEN, meaning the branch, jump or call target.
REQ-012 The module SHALL have port call, input, 1, meaning a call (qualifies branch_taken; pushes the return address).
REQ-013 The module SHALL have port ret, input, 1, meaning a return (pops the RAS).
REQ-014 The module SHALL have port PC_Out, output, XLEN, meaning the current PC.
REQ-015 The module SHALL have port PC_Plus, output, XLEN, meaning PC_Out+INC (combinational).
REQ-016 The module SHALL have ports ras_empty and ras_full, output, 1 each, meaning the RAS occupancy flags.
REQ-017 The module SHALL have port ras_underflow, output, 1, meaning a one-cycle registered pulse on a pop from an empty RAS.
REQ-018 The module SHALL have port misaligned, output, 1, meaning PC_Out[1] is set (combinational).

Function
REQ-019 Next-PC priority per rising edge SHALL be: flush > stall (PCWrite=0) > ret > branch_taken > sequential.
REQ-020 On flush, PC_Out SHALL take {flush_target[XLEN-1:1],1'b0} regardless of PCWrite; the RAS SHALL be unchanged; ras_underflow SHALL be 0.
REQ-021 On a stall without flush, PC_Out, RAS contents, count and pointer SHALL all hold, and ras_underflow SHALL be 0.
REQ-022 On ret with a non-empty RAS, PC_Out SHALL take the top entry and the count SHALL decrement.
REQ-023 On ret with an empty RAS, PC_Out SHALL take {branch_target[XLEN-1:1],0} and ras_underflow SHALL pulse 1 for exactly one cycle.
REQ-024 On branch_taken, PC_Out SHALL take {branch_target[XLEN-1:1],0}.
REQ-025 On branch_taken with call, PC_Out+INC SHALL be pushed onto the RAS.
REQ-026 call without branch_taken SHALL be ignored.
REQ-027 A push onto a full RAS SHALL overwrite the oldest entry (circular buffer); the count SHALL stay RAS_DEPTH.
REQ-028 ret together with call and branch_taken in the same cycle SHALL take next PC from the top entry and replace that top entry with PC_Out+INC, leaving the count unchanged.
REQ-029 If ret, call and branch_taken coincide with an empty RAS, the module SHALL apply REQ-023 and then push, giving count 1.
REQ-030 With no event, PC_Out SHALL take PC_Out+INC, with modulo 2^XLEN wrap-around.
REQ-031 ras_empty SHALL equal (count==0) and ras_full SHALL equal (count==RAS_DEPTH), both combinational from registered state.

Reset
REQ-032 While reset=0, PC_Out SHALL equal RESET_VECTOR, count SHALL be 0, the pointer SHALL be 0 and ras_underflow SHALL be 0, asynchronously and independent of clk.
REQ-033 RAS entry contents SHALL need no reset.
REQ-034 On the first rising edge after reset rises, normal operation SHALL apply (next PC = RESET_VECTOR+INC with no event), with no extra hold cycle.
REQ-035 Reset asserted mid-operation SHALL discard any in-flight push or pop.

Verification
REQ-036 The bench SHALL cover: reset low, then release, 3 idle edges -> PC_Out = 0, 4, 8, 12; PCWrite=0 for 2 edges -> PC_Out holds 12.
REQ-037 The bench SHALL cover: at PC 0x100, call+branch_taken to 0x400 -> PC_Out=0x400, ras_empty=0; next ret -> PC_Out=0x104, ras_empty=1.
REQ-038 The bench SHALL cover: 5 calls with RAS_DEPTH=4 from PCs A..E -> ras_full=1; then 4 rets -> E+4, D+4, C+4, B+4; 5th ret -> PC_Out=branch_target, ras_underflow=1 for one cycle.
REQ-039 The bench SHALL cover: flush=1 with flush_target=0x80000001 while PCWrite=0 and ret=1 -> PC_Out=0x80000000, RAS unchanged.
REQ-040 The bench SHALL cover: PC=0xFFFF_FFFF_FFFF_FFFC, idle edge -> PC_Out=0; with XLEN=32, check the same wrap at 0xFFFFFFFC.
REQ-041 The bench SHALL cover: reset asserted asynchronously between edges during a call -> PC_Out=RESET_VECTOR immediately, ras_empty=1.
